// File: rtl/img_pkt_fifo_reader.sv
// Read side of the image packetiser FIFO: starts a UDP frame once a full packet is
// buffered, then answers tx_req with a header word followed by payload. Option: IMG_PKT_RD_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for fifo_rd_cnt >= PKT_WORDS
// START     | one-cycle tx_start_en pulse, header latched
// SEND      | serving tx_req: header at idx 0, FIFO words at idx 1..PKT_WORDS
// WAIT_DONE | packet handed over, waiting for tx_done (or timeout)
module img_pkt_fifo_reader #(
   parameter int PKT_WORDS   = 256,
   parameter int CNT_W       = 12,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             img_vs,
   input  logic [CNT_W-1:0] fifo_rd_cnt,
   input  logic             fifo_empty,
   input  logic [31:0]      fifo_rd_data,
   output logic             fifo_rd_en,
   input  logic             tx_req,
   input  logic             tx_done,
   output logic             tx_start_en,
   output logic [15:0]      tx_byte_num,
   output logic [31:0]      udp_tx_data,
   output logic             pkt_busy,
   output logic [15:0]      frame_cnt,
   output logic             udf_err,
   output logic             to_err
);

   localparam int               IDX_W    = $clog2(PKT_WORDS + 1);
   localparam logic [CNT_W-1:0] PKT_THR  = CNT_W'(PKT_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS);
   localparam logic [15:0]      BYTE_NUM = 16'((PKT_WORDS + 1) * 4);

   if (PKT_WORDS < 1 || PKT_WORDS > 2047 || TIMEOUT_CYC < 1) begin : g_param_chk
      $error("img_pkt_fifo_reader: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, START, SEND, WAIT_DONE} state_t;
   typedef enum logic [1:0] {SEL_ZERO, SEL_HDR, SEL_FIFO} sel_t;

   state_t           state, state_nxt;
   sel_t             sel;
   logic [IDX_W-1:0] idx;
   logic [15:0]      pkt_idx;
   logic [31:0]      header;
   logic             pending;
   logic             vs_d;
   logic             vs_rise;
   logic             thresh;
   logic             last_word;
   logic             tmo_hit;

   assign thresh    = (fifo_rd_cnt >= PKT_THR);
   assign vs_rise   = img_vs & ~vs_d;
   assign last_word = (idx == LAST_IDX);
   assign pkt_busy  = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      fifo_rd_en  = 1'b0;
      tx_start_en = 1'b0;
      case (state)
         IDLE: begin
            if (thresh) state_nxt = START;
         end
         START: begin
            tx_start_en = 1'b1;
            state_nxt   = SEND;
         end
         SEND: begin
            if (tx_req) begin
               fifo_rd_en = (idx != '0) & ~fifo_empty;
               if (last_word) state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_done || tmo_hit) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A new frame clears pkt_idx only at the next START so the packet in flight keeps its header.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_byte_num <= '0;
         vs_d        <= 1'b0;
         frame_cnt   <= '0;
         pending     <= 1'b0;
         pkt_idx     <= '0;
         header      <= '0;
         idx         <= '0;
         sel         <= SEL_ZERO;
         udf_err     <= 1'b0;
      end else begin
         tx_byte_num <= BYTE_NUM;
         vs_d        <= img_vs;
         sel         <= SEL_ZERO;
         if (vs_rise) frame_cnt <= frame_cnt + 16'd1;
         if (vs_rise)              pending <= 1'b1;
         else if (state == START)  pending <= 1'b0;
         case (state)
            START: begin
               header <= {8'hA5, frame_cnt[7:0], pending ? 16'h0000 : pkt_idx};
               idx    <= '0;
               if (pending) pkt_idx <= '0;
            end
            SEND: begin
               if (tx_req) begin
                  idx <= idx + IDX_W'(1);
                  if (idx == '0) begin
                     sel <= SEL_HDR;
                  end else if (fifo_empty) begin
                     sel     <= SEL_ZERO;
                     udf_err <= 1'b1;
                  end else begin
                     sel <= SEL_FIFO;
                  end
                  if (last_word) pkt_idx <= pkt_idx + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // FIFO data arrives one cycle after the read strobe, so only the select is registered.
   always_comb begin
      udp_tx_data = '0;
      case (sel)
         SEL_HDR:  udp_tx_data = header;
         SEL_FIFO: udp_tx_data = fifo_rd_data;
         default:  udp_tx_data = '0;
      endcase
   end

`ifdef IMG_PKT_RD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             to_err_q;

   assign tmo_hit = (state == WAIT_DONE) && !tx_done && (tmo_cnt == '0);
   assign to_err  = to_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt  <= '0;
         to_err_q <= 1'b0;
      end else begin
         if (state == SEND && state_nxt == WAIT_DONE)
            tmo_cnt <= TMO_W'(TIMEOUT_CYC - 1);
         else if (state == WAIT_DONE && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - TMO_W'(1);
         if (tmo_hit) to_err_q <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign to_err  = 1'b0;
`endif

endmodule

// File: tb/tb_img_pkt_fifo_reader.sv
// Directed bench for img_pkt_fifo_reader: vector table for start-up, hand sequences
// for packet streaming, underflow, frame change, back-to-back start, timeout and reset.
module tb_img_pkt_fifo_reader;
   localparam int PKT_WORDS   = 256;
   localparam int CNT_W       = 12;
   localparam int TIMEOUT_CYC = 100;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             img_vs;
   logic [CNT_W-1:0] fifo_rd_cnt;
   logic             fifo_empty;
   logic [31:0]      fifo_rd_data = '0;
   logic             fifo_rd_en;
   logic             tx_req;
   logic             tx_done;
   logic             tx_start_en;
   logic [15:0]      tx_byte_num;
   logic [31:0]      udp_tx_data;
   logic             pkt_busy;
   logic [15:0]      frame_cnt;
   logic             udf_err;
   logic             to_err;

   logic [31:0]      fifo_word = '0;
   logic [31:0]      exp_word  = '0;
   int               checks = 0;
   int               errors = 0;

   typedef struct {
      logic [CNT_W-1:0] cnt;
      logic             req;
      logic             done;
      logic             exp_rd;
      logic             exp_start;
      logic             exp_busy;
      logic             chk_data;
      logic [31:0]      exp_data;
   } vec_t;

   vec_t vecs [7];

   always #5 clk = ~clk;

   img_pkt_fifo_reader #(
      .PKT_WORDS   (PKT_WORDS),
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .img_vs       (img_vs),
      .fifo_rd_cnt  (fifo_rd_cnt),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .tx_req       (tx_req),
      .tx_done      (tx_done),
      .tx_start_en  (tx_start_en),
      .tx_byte_num  (tx_byte_num),
      .udp_tx_data  (udp_tx_data),
      .pkt_busy     (pkt_busy),
      .frame_cnt    (frame_cnt),
      .udf_err      (udf_err),
      .to_err       (to_err)
   );

   // FIFO stub preloaded with an incrementing word sequence 0,1,2,...
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= fifo_word;
         fifo_word    <= fifo_word + 32'd1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [CNT_W-1:0] cnt, input logic req, input logic done,
                        input logic empty, input logic vs);
      fifo_rd_cnt = cnt;
      tx_req      = req;
      tx_done     = done;
      fifo_empty  = empty;
      img_vs      = vs;
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic word(input string name, input logic empty, input logic vs,
                       input logic exp_rd, input logic [31:0] exp_data);
      drive(12'd256, 1'b1, 1'b0, empty, vs);
      #1 chk({name, "_rd"}, 32'(fifo_rd_en), 32'(exp_rd));
      edge1();
      chk({name, "_data"}, udp_tx_data, exp_data);
   endtask

   task automatic send_pkt(input string tag, input logic [31:0] hdr);
      word({tag, "_hdr"}, 1'b0, 1'b0, 1'b0, hdr);
      for (int k = 1; k <= PKT_WORDS; k++) begin
         word(tag, 1'b0, 1'b0, 1'b1, exp_word);
         exp_word = exp_word + 32'd1;
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"},  32'(pkt_busy),    32'd0);
      chk({tag, "_start"}, 32'(tx_start_en), 32'd0);
      chk({tag, "_rd"},    32'(fifo_rd_en),  32'd0);
      chk({tag, "_data"},  udp_tx_data,      32'd0);
      chk({tag, "_bytes"}, 32'(tx_byte_num), 32'd0);
      chk({tag, "_frame"}, 32'(frame_cnt),   32'd0);
      chk({tag, "_udf"},   32'(udf_err),     32'd0);
      chk({tag, "_to"},    32'(to_err),      32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          cnt     req   done  rd    start busy  chkd  data
      vecs[0] = '{12'd255, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{12'd255, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      vecs[2] = '{12'd256, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
      vecs[3] = '{12'd256, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      vecs[4] = '{12'd256, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA500_0000};
      vecs[5] = '{12'd256, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0};
      vecs[6] = '{12'd256, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd1};

      rst_n = 1'b0;
      drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
      #3 chk_reset("rst");
      edge1();
      edge1();
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         drive(vecs[i].cnt, vecs[i].req, vecs[i].done, 1'b0, 1'b0);
         #1 chk($sformatf("vec%0d_rd", i), 32'(fifo_rd_en), 32'(vecs[i].exp_rd));
         edge1();
         chk($sformatf("vec%0d_start", i), 32'(tx_start_en), 32'(vecs[i].exp_start));
         chk($sformatf("vec%0d_busy", i),  32'(pkt_busy),    32'(vecs[i].exp_busy));
         if (vecs[i].chk_data)
            chk($sformatf("vec%0d_data", i), udp_tx_data, vecs[i].exp_data);
      end
      chk("byte_num", 32'(tx_byte_num), 32'd1028);
      exp_word = 32'd2;

      // Rest of packet 1, consecutive with the table's tx_req cycles
      for (int k = 3; k <= PKT_WORDS; k++) begin
         word("p1", 1'b0, 1'b0, 1'b1, exp_word);
         exp_word = exp_word + 32'd1;
      end
      chk("p1_reads", fifo_word, 32'd256);
      chk("p1_udf", 32'(udf_err), 32'd0);
      chk("p1_wait_busy", 32'(pkt_busy), 32'd1);

      // tx_req in WAIT_DONE is ignored
      for (int k = 0; k < 3; k++) word("wd_req", 1'b0, 1'b0, 1'b0, 32'd0);
      chk("wd_reads", fifo_word, 32'd256);

      // tx_done with threshold met: one IDLE cycle then START
      drive(12'd256, 1'b0, 1'b1, 1'b0, 1'b0);
      edge1();
      chk("b2b_idle_busy",  32'(pkt_busy),    32'd0);
      chk("b2b_idle_start", 32'(tx_start_en), 32'd0);
      drive(12'd256, 1'b0, 1'b0, 1'b0, 1'b0);
      edge1();
      chk("b2b_start", 32'(tx_start_en), 32'd1);
      edge1();
      chk("b2b_start_end", 32'(tx_start_en), 32'd0);

      // Packet 2: vsync mid-packet, FIFO empty at idx 10
      word("p2_hdr", 1'b0, 1'b0, 1'b0, 32'hA500_0001);
      for (int k = 1; k <= PKT_WORDS; k++) begin
         if (k == 10) begin
            word("p2_empty", 1'b1, 1'b0, 1'b0, 32'd0);
         end else begin
            word("p2", 1'b0, (k == 5), 1'b1, exp_word);
            exp_word = exp_word + 32'd1;
         end
         if (k == 8)  chk("p2_frame_cnt", 32'(frame_cnt), 32'd1);
         if (k == 11) chk("p2_udf_set", 32'(udf_err), 32'd1);
      end

      // tx_done without threshold: stay idle
      drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
      edge1();
      chk("p2_done_busy", 32'(pkt_busy), 32'd0);
      drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         edge1();
         chk("idle_no_start", 32'(tx_start_en), 32'd0);
      end
      drive(12'd256, 1'b0, 1'b0, 1'b0, 1'b0);
      edge1();
      chk("p3_start", 32'(tx_start_en), 32'd1);
      edge1();

      // Packet 3: new frame, pkt_idx cleared
      send_pkt("p3", 32'hA501_0000);
      chk("p3_udf_sticky", 32'(udf_err), 32'd1);
      chk("p3_reads", fifo_word, 32'd767);

      drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef IMG_PKT_RD_TIMEOUT_EN
      repeat (TIMEOUT_CYC - 1) edge1();
      chk("tmo_pre_busy", 32'(pkt_busy), 32'd1);
      chk("tmo_pre_err",  32'(to_err),   32'd0);
      edge1();
      chk("tmo_busy", 32'(pkt_busy), 32'd0);
      chk("tmo_err",  32'(to_err),   32'd1);
`else
      repeat (150) edge1();
      chk("no_tmo_busy", 32'(pkt_busy), 32'd1);
      chk("no_tmo_err",  32'(to_err),   32'd0);
      drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
      edge1();
      chk("late_done_busy", 32'(pkt_busy), 32'd0);
`endif

      // Reset asserted mid-packet
      drive(12'd256, 1'b0, 1'b0, 1'b0, 1'b0);
      edge1();
      edge1();
      word("r_hdr", 1'b0, 1'b0, 1'b0, 32'hA501_0001);
      for (int k = 0; k < 2; k++) begin
         word("r", 1'b0, 1'b0, 1'b1, exp_word);
         exp_word = exp_word + 32'd1;
      end
      drive(12'd256, 1'b1, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1 chk_reset("midrst");
      edge1();
      rst_n = 1'b1;
      drive(12'd256, 1'b0, 1'b0, 1'b0, 1'b0);
      edge1();
      chk("post_rst_start", 32'(tx_start_en), 32'd1);
      edge1();
      word("post_rst_hdr", 1'b0, 1'b0, 1'b0, 32'hA500_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
